sga_renderer: RTL and testbench

SGA_RENDERER -- requirements
Module: sga_renderer

---
 rtl/sga_renderer_if.sv | 34 +++
 rtl/sga_renderer.sv | 180 ++++++++++++++++++
 tb/tb_sga_renderer.sv | 434 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sga_renderer_if.sv
// Render control and body-memory bus between a snake game core and sga_renderer.
// The renderer sits on the slave side; the game logic (or a bench) is the master.
interface sga_renderer_if;
    logic       render_clr;
    logic       render_start;
    logic [6:0] snake_size;
    logic [5:0] apple_pos;
    logic [5:0] body_addr;
    logic [5:0] body_data;
    logic       render_finish;
    logic       busy;

    modport master (
        output render_clr,
        output render_start,
        output snake_size,
        output apple_pos,
        output body_data,
        input  body_addr,
        input  render_finish,
        input  busy
    );

    modport slave (
        input  render_clr,
        input  render_start,
        input  snake_size,
        input  apple_pos,
        input  body_data,
        output body_addr,
        output render_finish,
        output busy
    );
endinterface

// File: rtl/sga_renderer.sv
// Snake game renderer for an 8x8 LED matrix.
// A frame is built in a back buffer (clear, body segments, apple) and copied in
// one cycle to the front buffer, which a free-running row scanner displays.
// Buffer bit y*8+x corresponds to cell (x,y); positions arrive as {x[5:3], y[2:0]}.
module sga_renderer #(
    parameter int SCAN_DIV = 1000,
    parameter int MAX_SIZE = 64
) (
    input  logic          clock,
    input  logic          restart,
    sga_renderer_if.slave bus,
    output logic [7:0]    row_sel,
    output logic [7:0]    col_data,
    output logic [2:0]    db_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        ADDR  = 3'd2,
        WRITE = 3'd3,
        APPLE = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam logic [6:0] MAX_N = 7'(MAX_SIZE);
    localparam int         DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    state_t      state_q, state_d;
    logic [6:0]  segCount_q, segCount_d;
    logic [5:0]  apple_q, apple_d;
    logic [6:0]  segIdx_q, segIdx_d;
    logic [2:0]  clearRow_q, clearRow_d;
    logic [5:0]  addr_q, addr_d;
    logic [63:0] backBuf_q, backBuf_d;
    logic [63:0] frontBuf_q, frontBuf_d;

    logic [DIV_W-1:0] scanCnt_q, scanCnt_d;
    logic [7:0]       rowSel_q, rowSel_d;

    logic [6:0] sizeClamped;
    logic [6:0] segNext;
    logic [5:0] bodyCell;
    logic [5:0] appleCell;

    // Segment count is limited to what the body memory can hold.
    assign sizeClamped = (bus.snake_size > MAX_N) ? MAX_N : bus.snake_size;
    assign segNext     = segIdx_q + 7'd1;

    // Position {x,y} maps to buffer bit y*8+x, i.e. the fields swapped.
    assign bodyCell  = {bus.body_data[2:0], bus.body_data[5:3]};
    assign appleCell = {apple_q[2:0], apple_q[5:3]};

    // Next-state and datapath updates for the render sequence; clear overrides all.
    always_comb begin
        state_d    = state_q;
        segCount_d = segCount_q;
        apple_d    = apple_q;
        segIdx_d   = segIdx_q;
        clearRow_d = clearRow_q;
        addr_d     = addr_q;
        backBuf_d  = backBuf_q;
        frontBuf_d = frontBuf_q;

        case (state_q)
            IDLE, DONE: begin
                if (bus.render_start) begin
                    state_d    = CLEAR;
                    segCount_d = sizeClamped;
                    apple_d    = bus.apple_pos;
                    clearRow_d = 3'd0;
                    segIdx_d   = 7'd0;
                end
            end
            CLEAR: begin
                backBuf_d[{clearRow_q, 3'b000} +: 8] = 8'h00;
                clearRow_d = clearRow_q + 3'd1;
                if (clearRow_q == 3'd7) begin
                    if (segCount_q == 7'd0) begin
                        state_d = APPLE;
                    end else begin
                        state_d = ADDR;
                        addr_d  = 6'd0;
                    end
                end
            end
            ADDR: begin
                state_d = WRITE;
            end
            WRITE: begin
                backBuf_d[bodyCell] = 1'b1;
                segIdx_d = segNext;
                if (segNext < segCount_q) begin
                    state_d = ADDR;
                    addr_d  = segNext[5:0];
                end else begin
                    state_d = APPLE;
                end
            end
            APPLE: begin
                backBuf_d[appleCell] = 1'b1;
                frontBuf_d = backBuf_q | (64'd1 << appleCell);
                state_d    = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (bus.render_clr) begin
            state_d    = IDLE;
            backBuf_d  = '0;
            frontBuf_d = '0;
            segIdx_d   = 7'd0;
            clearRow_d = 3'd0;
        end
    end

    // Render state registers with synchronous restart.
    always_ff @(posedge clock) begin
        if (restart) begin
            state_q    <= IDLE;
            segCount_q <= 7'd0;
            apple_q    <= 6'd0;
            segIdx_q   <= 7'd0;
            clearRow_q <= 3'd0;
            addr_q     <= 6'd0;
            backBuf_q  <= '0;
            frontBuf_q <= '0;
        end else begin
            state_q    <= state_d;
            segCount_q <= segCount_d;
            apple_q    <= apple_d;
            segIdx_q   <= segIdx_d;
            clearRow_q <= clearRow_d;
            addr_q     <= addr_d;
            backBuf_q  <= backBuf_d;
            frontBuf_q <= frontBuf_d;
        end
    end

    // Scan divider: advance to the next row each time the divider wraps.
    always_comb begin
        scanCnt_d = scanCnt_q + 1'b1;
        rowSel_d  = rowSel_q;
        if (scanCnt_q == DIV_LAST) begin
            scanCnt_d = '0;
            rowSel_d  = {rowSel_q[6:0], rowSel_q[7]};
        end
    end

    // Scan registers run independently of the render FSM and of render_clr.
    always_ff @(posedge clock) begin
        if (restart) begin
            scanCnt_q <= '0;
            rowSel_q  <= 8'b0000_0001;
        end else begin
            scanCnt_q <= scanCnt_d;
            rowSel_q  <= rowSel_d;
        end
    end

    // Column drive is the front-buffer row picked by the one-hot row select.
    always_comb begin
        col_data = 8'h00;
        for (int r = 0; r < 8; r++) begin
            if (rowSel_q[r]) begin
                col_data = col_data | frontBuf_q[r*8 +: 8];
            end
        end
    end

    assign row_sel           = rowSel_q;
    assign db_state          = state_q;
    assign bus.body_addr     = addr_q;
    assign bus.render_finish = (state_q == DONE);
    assign bus.busy          = (state_q != IDLE) && (state_q != DONE);

endmodule

// File: tb/tb_sga_renderer.sv
// Bench for sga_renderer: random body memories rendered and compared, through
// the row scanner, against a cell-level frame model plus finish-time arithmetic.
module tb_sga_renderer;

    localparam int SDIV = 4;

    logic       clock;
    logic       restart;
    logic [7:0] row_sel;
    logic [7:0] col_data;
    logic [2:0] db_state;

    int passCount;
    int checkCount;
    int cycleCount;
    int startCycle;

    logic [5:0] bodyMem [64];

    sga_renderer_if bus ();

    sga_renderer #(
        .SCAN_DIV(SDIV),
        .MAX_SIZE(64)
    ) dut (
        .clock   (clock),
        .restart (restart),
        .bus     (bus.slave),
        .row_sel (row_sel),
        .col_data(col_data),
        .db_state(db_state)
    );

    // Free-running clock and edge counter.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cycleCount <= cycleCount + 1;

    // One-cycle synchronous body RAM.
    always @(posedge clock) bus.body_data <= bodyMem[bus.body_addr];

    // Reference frame: each body cell and the apple light bit y*8+x.
    function automatic logic [63:0] modelFrame(int n, logic [5:0] apple);
        logic [63:0] f;
        int m;
        int x;
        int y;
        f = '0;
        m = (n > 64) ? 64 : n;
        for (int i = 0; i < m; i++) begin
            x = int'(bodyMem[i][5:3]);
            y = int'(bodyMem[i][2:0]);
            f[y*8 + x] = 1'b1;
        end
        x = int'(apple[5:3]);
        y = int'(apple[2:0]);
        f[y*8 + x] = 1'b1;
        return f;
    endfunction

    task automatic fillRandomBody();
        for (int i = 0; i < 64; i++) bodyMem[i] = 6'($urandom);
    endtask

    task automatic doRestart();
        @(negedge clock);
        restart = 1'b1;
        bus.render_start = 1'b0;
        bus.render_clr = 1'b0;
        repeat (2) @(negedge clock);
        restart = 1'b0;
    endtask

    // Reassembles the displayed frame by watching the scanner through all rows.
    task automatic captureFrame(output logic [63:0] frame, output bit ok);
        logic [7:0] seen;
        bit hit;
        frame = '0;
        seen = '0;
        ok = 1'b1;
        for (int c = 0; c < 8*SDIV + 4; c++) begin
            @(negedge clock);
            hit = 1'b0;
            for (int r = 0; r < 8; r++) begin
                if (row_sel === 8'(1 << r)) begin
                    frame[r*8 +: 8] = col_data;
                    seen[r] = 1'b1;
                    hit = 1'b1;
                end
            end
            if (!hit) ok = 1'b0;
        end
        if (seen !== 8'hFF) ok = 1'b0;
    endtask

    // Starts one render and observes it until render_finish (bounded).
    task automatic runFrame(input int n, input logic [5:0] apple,
                            output int finishEdge, output int reads,
                            output bit seqErr, output bit addrChanged);
        logic [5:0] lastAddr;
        @(negedge clock);
        bus.snake_size = 7'(n);
        bus.apple_pos = apple;
        bus.render_start = 1'b1;
        startCycle = cycleCount + 1;
        lastAddr = bus.body_addr;
        finishEdge = -1;
        reads = 0;
        seqErr = 1'b0;
        addrChanged = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(posedge clock);
            #1;
            if (c == 0) bus.render_start = 1'b0;
            if (db_state == 3'd2) begin
                if (bus.body_addr !== 6'(reads)) seqErr = 1'b1;
                reads++;
            end
            if (bus.body_addr !== lastAddr) addrChanged = 1'b1;
            if (bus.render_finish === 1'b1) begin
                finishEdge = cycleCount - startCycle;
                break;
            end
        end
    endtask

    task automatic test_reset();
        doRestart();
        checkCount++;
        if (db_state !== 3'd0) $display("[TB] FAIL reset_state: got %0d expected 0", db_state);
        else passCount++;
        checkCount++;
        if (bus.busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", bus.busy);
        else passCount++;
        checkCount++;
        if (bus.render_finish !== 1'b0) $display("[TB] FAIL reset_finish: got %b expected 0", bus.render_finish);
        else passCount++;
        checkCount++;
        if (bus.body_addr !== 6'd0) $display("[TB] FAIL reset_addr: got %0d expected 0", bus.body_addr);
        else passCount++;
        checkCount++;
        if (row_sel !== 8'b0000_0001) $display("[TB] FAIL reset_rowsel: got %b expected 00000001", row_sel);
        else passCount++;
        checkCount++;
        if (col_data !== 8'h00) $display("[TB] FAIL reset_coldata: got %h expected 00", col_data);
        else passCount++;
    endtask

    task automatic test_basic();
        int fe, reads;
        bit seqErr, addrCh, ok;
        logic [63:0] frame, expFrame;
        logic [5:0] apple;
        bodyMem[0] = {3'd1, 3'd1};
        bodyMem[1] = {3'd2, 3'd1};
        bodyMem[2] = {3'd3, 3'd1};
        apple = {3'd5, 3'd6};
        expFrame = modelFrame(3, apple);
        runFrame(3, apple, fe, reads, seqErr, addrCh);
        checkCount++;
        if (fe !== 15) $display("[TB] FAIL basic_finish_edge: got %0d expected 15", fe);
        else passCount++;
        checkCount++;
        if (reads !== 3 || seqErr) $display("[TB] FAIL basic_reads: got %0d seqErr=%b expected 3 seqErr=0", reads, seqErr);
        else passCount++;
        captureFrame(frame, ok);
        checkCount++;
        if (!ok || frame !== expFrame) $display("[TB] FAIL basic_frame: got %h expected %h", frame, expFrame);
        else passCount++;
        checkCount++;
        if (frame[8 +: 8] !== 8'b0000_1110 || frame[48 +: 8] !== 8'b0010_0000)
            $display("[TB] FAIL basic_rows: got row1=%b row6=%b expected 00001110 00100000", frame[8 +: 8], frame[48 +: 8]);
        else passCount++;
    endtask

    task automatic test_zero_size();
        int fe, reads;
        bit seqErr, addrCh, ok;
        logic [63:0] frame;
        runFrame(0, 6'd0, fe, reads, seqErr, addrCh);
        checkCount++;
        if (fe !== 9) $display("[TB] FAIL zero_finish_edge: got %0d expected 9", fe);
        else passCount++;
        checkCount++;
        if (reads !== 0 || addrCh) $display("[TB] FAIL zero_addr: got reads=%0d changed=%b expected 0 0", reads, addrCh);
        else passCount++;
        captureFrame(frame, ok);
        checkCount++;
        if (!ok || frame !== 64'd1) $display("[TB] FAIL zero_frame: got %h expected %h", frame, 64'd1);
        else passCount++;
    endtask

    task automatic test_clamp();
        int fe, reads;
        bit seqErr, addrCh, ok;
        logic [63:0] frame, expFrame;
        logic [5:0] apple;
        fillRandomBody();
        apple = 6'($urandom);
        expFrame = modelFrame(100, apple);
        runFrame(100, apple, fe, reads, seqErr, addrCh);
        checkCount++;
        if (fe !== 137) $display("[TB] FAIL clamp_finish_edge: got %0d expected 137", fe);
        else passCount++;
        checkCount++;
        if (reads !== 64 || seqErr) $display("[TB] FAIL clamp_reads: got %0d seqErr=%b expected 64 seqErr=0", reads, seqErr);
        else passCount++;
        captureFrame(frame, ok);
        checkCount++;
        if (!ok || frame !== expFrame) $display("[TB] FAIL clamp_frame: got %h expected %h", frame, expFrame);
        else passCount++;
    endtask

    task automatic test_random();
        int fe, reads, n;
        bit seqErr, addrCh, ok;
        logic [63:0] frame, expFrame;
        logic [5:0] apple;
        for (int it = 0; it < 4; it++) begin
            fillRandomBody();
            n = $urandom_range(1, 20);
            apple = 6'($urandom);
            expFrame = modelFrame(n, apple);
            runFrame(n, apple, fe, reads, seqErr, addrCh);
            checkCount++;
            if (fe !== 2*n + 9) $display("[TB] FAIL random_finish_edge: n=%0d got %0d expected %0d", n, fe, 2*n + 9);
            else passCount++;
            checkCount++;
            if (reads !== n || seqErr) $display("[TB] FAIL random_reads: got %0d seqErr=%b expected %0d seqErr=0", reads, seqErr, n);
            else passCount++;
            captureFrame(frame, ok);
            checkCount++;
            if (!ok || frame !== expFrame) $display("[TB] FAIL random_frame: got %h expected %h", frame, expFrame);
            else passCount++;
        end
    endtask

    task automatic test_back_to_back();
        int fe, reads;
        bit seqErr, addrCh, ok;
        logic [63:0] frame, expA, expB;
        logic [5:0] appleA, appleB;
        fillRandomBody();
        appleA = 6'($urandom);
        expA = modelFrame(5, appleA);
        runFrame(5, appleA, fe, reads, seqErr, addrCh);
        fillRandomBody();
        appleB = 6'($urandom);
        expB = modelFrame(30, appleB);
        @(negedge clock);
        bus.snake_size = 7'd30;
        bus.apple_pos = appleB;
        bus.render_start = 1'b1;
        startCycle = cycleCount + 1;
        @(negedge clock);
        bus.render_start = 1'b0;
        repeat (2) @(negedge clock);
        bus.snake_size = 7'd2;
        bus.render_start = 1'b1;
        @(negedge clock);
        bus.render_start = 1'b0;
        captureFrame(frame, ok);
        checkCount++;
        if (!ok || frame !== expA) $display("[TB] FAIL b2b_front_held: got %h expected %h", frame, expA);
        else passCount++;
        checkCount++;
        if (bus.busy !== 1'b1) $display("[TB] FAIL b2b_busy: got %b expected 1", bus.busy);
        else passCount++;
        fe = -1;
        for (int c = 0; c < 200; c++) begin
            @(posedge clock);
            #1;
            if (bus.render_finish === 1'b1) begin
                fe = cycleCount - startCycle;
                break;
            end
        end
        checkCount++;
        if (fe !== 69) $display("[TB] FAIL b2b_finish_edge: got %0d expected 69", fe);
        else passCount++;
        captureFrame(frame, ok);
        checkCount++;
        if (!ok || frame !== expB) $display("[TB] FAIL b2b_frame: got %h expected %h", frame, expB);
        else passCount++;
    endtask

    task automatic test_clear();
        bit found, ok;
        logic [63:0] frame;
        fillRandomBody();
        @(negedge clock);
        bus.snake_size = 7'd5;
        bus.apple_pos = 6'($urandom);
        bus.render_start = 1'b1;
        @(negedge clock);
        bus.render_start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (db_state === 3'd3 && bus.body_addr === 6'd2) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        checkCount++;
        if (!found) $display("[TB] FAIL clear_reach_write2: got timeout expected WRITE of segment 2");
        else passCount++;
        bus.render_clr = 1'b1;
        @(posedge clock);
        #1;
        checkCount++;
        if (db_state !== 3'd0 || bus.busy !== 1'b0 || bus.render_finish !== 1'b0)
            $display("[TB] FAIL clear_idle: got state=%0d busy=%b finish=%b expected 0 0 0", db_state, bus.busy, bus.render_finish);
        else passCount++;
        @(negedge clock);
        bus.render_clr = 1'b0;
        captureFrame(frame, ok);
        checkCount++;
        if (!ok || frame !== 64'd0) $display("[TB] FAIL clear_frame: got %h expected 0", frame);
        else passCount++;
        @(negedge clock);
        bus.render_start = 1'b1;
        bus.render_clr = 1'b1;
        @(posedge clock);
        #1;
        checkCount++;
        if (db_state !== 3'd0) $display("[TB] FAIL clear_beats_start: got %0d expected 0", db_state);
        else passCount++;
        @(negedge clock);
        bus.render_start = 1'b0;
        bus.render_clr = 1'b0;
    endtask

    task automatic test_scan();
        int fe, reads, row0, expRow;
        bit seqErr, addrCh, found;
        logic [7:0] prev;
        for (int i = 0; i < 8; i++) bodyMem[i] = {3'(i), 3'd3};
        runFrame(8, {3'd0, 3'd3}, fe, reads, seqErr, addrCh);
        checkCount++;
        if (fe !== 25) $display("[TB] FAIL scan_finish_edge: got %0d expected 25", fe);
        else passCount++;
        @(negedge clock);
        prev = row_sel;
        found = 1'b0;
        for (int c = 0; c < 2*SDIV; c++) begin
            @(negedge clock);
            if (row_sel !== prev) begin
                found = 1'b1;
                break;
            end
        end
        row0 = -1;
        for (int r = 0; r < 8; r++) if (row_sel === 8'(1 << r)) row0 = r;
        checkCount++;
        if (!found || row0 < 0) $display("[TB] FAIL scan_sync: got row_sel=%b expected a one-hot row change", row_sel);
        else passCount++;
        if (row0 < 0) row0 = 0;
        for (int i = 0; i < 40; i++) begin
            if (i > 0) @(negedge clock);
            expRow = (row0 + i / SDIV) % 8;
            checkCount++;
            if (row_sel !== 8'(1 << expRow)) $display("[TB] FAIL scan_rowsel: got %b expected %b", row_sel, 8'(1 << expRow));
            else passCount++;
            checkCount++;
            if (col_data !== ((expRow == 3) ? 8'hFF : 8'h00))
                $display("[TB] FAIL scan_coldata: row %0d got %h expected %h", expRow, col_data, (expRow == 3) ? 8'hFF : 8'h00);
            else passCount++;
        end
    endtask

    task automatic test_restart_abort();
        bit ok;
        logic [63:0] frame;
        fillRandomBody();
        @(negedge clock);
        bus.snake_size = 7'd20;
        bus.apple_pos = 6'($urandom);
        bus.render_start = 1'b1;
        @(negedge clock);
        bus.render_start = 1'b0;
        repeat (15) @(negedge clock);
        restart = 1'b1;
        @(negedge clock);
        restart = 1'b0;
        checkCount++;
        if (db_state !== 3'd0 || bus.busy !== 1'b0 || bus.render_finish !== 1'b0 || bus.body_addr !== 6'd0)
            $display("[TB] FAIL abort_state: got state=%0d busy=%b finish=%b addr=%0d expected 0 0 0 0",
                     db_state, bus.busy, bus.render_finish, bus.body_addr);
        else passCount++;
        repeat (30) @(negedge clock);
        checkCount++;
        if (bus.render_finish !== 1'b0) $display("[TB] FAIL abort_no_finish: got %b expected 0", bus.render_finish);
        else passCount++;
        captureFrame(frame, ok);
        checkCount++;
        if (!ok || frame !== 64'd0) $display("[TB] FAIL abort_frame: got %h expected 0", frame);
        else passCount++;
    endtask

    // Hard time limit so the run always ends.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        passCount = 0;
        checkCount = 0;
        cycleCount = 0;
        restart = 1'b1;
        bus.render_clr = 1'b0;
        bus.render_start = 1'b0;
        bus.snake_size = 7'd0;
        bus.apple_pos = 6'd0;
        for (int i = 0; i < 64; i++) bodyMem[i] = 6'd0;

        test_reset();
        test_basic();
        test_zero_size();
        test_clamp();
        test_random();
        test_back_to_back();
        test_clear();
        test_scan();
        test_restart_abort();

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
